q16_normalize_seq: RTL and testbench
====================================

Q16_NORMALIZE_SEQ -- requirements
Module: q16_normalize_seq

Interface
REQ-001 SHALL have parameter: ZERO_THRESH, 32'sd0, Q16.16 length at or below which the vector is treated as zero.
REQ-002 SHALL have ports (clock/reset first):
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input vector present.
- in_ready  output  1  block idle, can accept.
- in_x, in_y, in_z  input  32 each  signed Q16.16 vector components.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_x, out_y, out_z  output  32 each  signed Q16.16 normalized components.
- out_len  output  32  signed Q16.16 vector length.
- out_zero  output  1  zero/degenerate vector flag.
- busy  output  1  high in every state except IDLE.

Function
REQ-003 SHALL be a single-in-flight sequencer with states IDLE, DOT, SQRT, DIVX, DIVY, DIVZ, OUT.
REQ-004 in_ready SHALL equal (state==IDLE); accept occurs on a rising edge with in_valid && in_ready, registering in_x/y/z and moving to DOT.
REQ-005 DOT: capture dot = x*x+y*y+z*z, each product arithmetic-shifted right 16 bits with no rounding, summed mod 2^32 (overflow wraps); next SQRT.
REQ-006 SQRT: capture len = integer digit-by-digit sqrt of (dot<<16), 24 iterations; len = 0 when dot <= 0.
REQ-007 In SQRT, if computed len <= ZERO_THRESH: out_x/y/z = 0, out_zero = 1, out_len = len, next OUT; else out_zero = 0, next DIVX.
REQ-008 DIVX/DIVY/DIVZ: capture out_x/y/z = (comp<<16)/len in 64-bit signed, truncating toward zero, low 32 bits kept; one shared divider muxed by state.
REQ-009 DIVZ SHALL transition to OUT; out_valid SHALL equal (state==OUT).
REQ-010 Latency: out_valid high after the 5th rising edge following the accept edge on the normal path, and after the 2nd on the zero path.
REQ-011 In OUT, all out_* SHALL stay stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-012 in_valid is ignored outside IDLE; no new accept in the same cycle as the output handshake (throughput 1 per 7 cycles minimum).
REQ-013 out_* data registers SHALL hold their last values in IDLE until overwritten.
REQ-014 The divider SHALL never see len==0 (guaranteed by REQ-007 when ZERO_THRESH >= 0).

Reset
REQ-015 rst SHALL asynchronously force state=IDLE, out_x/y/z=0, out_len=0, out_zero=0, out_valid=0, busy=0, and internal dot/input registers=0.
REQ-016 in_ready SHALL read 1 while rst is high.
REQ-017 Reset mid-operation SHALL abandon the vector, with no out_valid pulse for it.

Structure
REQ-018 A shared package q16_pkg SHALL hold the q16_t typedef (signed 32-bit), Q16_ONE (32'sd65536), Q16_FRAC_BITS (16) and the state enum.
REQ-019 No new sub-module; SHALL instantiate existing primitives: one q16_dot3, one q16_sqrt, exactly one q16_div (operand muxed by state).
REQ-020 All arithmetic SHALL match the team C model bit-exactly.

Verification
REQ-021 (3,4,0) = 0x00030000, 0x00040000, 0 -> out_len 0x00050000, out_x 0x00009999, out_y 0x0000CCCC, out_z 0, out_zero 0, out_valid 5 edges after accept.
REQ-022 (-3,4,0) -> out_x 0xFFFF6667 (truncation toward zero), out_y 0x0000CCCC, out_len 0x00050000.
REQ-023 (0,0,0) -> out_zero 1, all outputs 0, out_valid 2 edges after accept; x = 0x01000000 (dot wraps to 0) -> same zero response.
REQ-024 Hold out_ready low 3 cycles in OUT while toggling in_valid and input data -> outputs stable, in_ready 0, no accept; out_ready high -> IDLE next edge.
REQ-025 Assert rst during DIVY -> all outputs 0 and in_ready 1 immediately; no out_valid; next vector (3,4,0) processes per REQ-021.
REQ-026 Back-to-back vectors with in_valid held high -> second accept exactly one edge after first output handshake.

Source files
------------

// File: rtl/q16_pkg.sv
// Shared Q16.16 types, constants and the normalize sequencer state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package q16_pkg;
  typedef logic signed [31:0] q16_t;

  localparam q16_t Q16_ONE       = 32'sd65536;
  localparam int   Q16_FRAC_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOT,
    S_SQRT,
    S_DIVX,
    S_DIVY,
    S_DIVZ,
    S_OUT
  } state_t;
endpackage

// File: rtl/q16_div.sv
// Q16.16 divide: (num<<16)/den in 64-bit signed, truncating toward zero, low 32 bits kept.
// Latency: combinational.
// Backpressure: none; ports i_num, i_den (q16_t, den nonzero) -> o_quo (q16_t).
module q16_div
  import q16_pkg::*;
(
  input  q16_t i_num,
  input  q16_t i_den,
  output q16_t o_quo
);
  logic signed [63:0] w_num, w_den, w_quo;

  assign w_num = {{32{i_num[31]}}, i_num} <<< Q16_FRAC_BITS;
  assign w_den = {{32{i_den[31]}}, i_den};
  assign w_quo = w_num / w_den;
  assign o_quo = w_quo[31:0];
endmodule

// File: rtl/q16_dot3.sv
// Q16.16 3-component dot product of a vector with itself: sum of (c*c)>>>16, wraps mod 2^32.
// Latency: combinational.
// Backpressure: none; ports i_x/i_y/i_z (q16_t) -> o_dot (q16_t).
module q16_dot3
  import q16_pkg::*;
(
  input  q16_t i_x,
  input  q16_t i_y,
  input  q16_t i_z,
  output q16_t o_dot
);
  logic signed [63:0] w_ex, w_ey, w_ez;
  logic signed [63:0] w_px, w_py, w_pz;

  assign w_ex = {{32{i_x[31]}}, i_x};
  assign w_ey = {{32{i_y[31]}}, i_y};
  assign w_ez = {{32{i_z[31]}}, i_z};

  assign w_px = w_ex * w_ex;
  assign w_py = w_ey * w_ey;
  assign w_pz = w_ez * w_ez;

  // Arithmetic shift by the fraction width then keeping 32 bits is just a bit slice.
  assign o_dot = w_px[Q16_FRAC_BITS +: 32] + w_py[Q16_FRAC_BITS +: 32] + w_pz[Q16_FRAC_BITS +: 32];
endmodule

// File: rtl/q16_sqrt.sv
// Q16.16 square root: floor sqrt of (dot<<16) by 24-step digit-by-digit; 0 for dot <= 0.
// Latency: combinational.
// Backpressure: none; ports i_dot (q16_t) -> o_len (q16_t).
module q16_sqrt
  import q16_pkg::*;
(
  input  q16_t i_dot,
  output q16_t o_len
);
  logic [47:0] w_n;
  logic [27:0] w_rem;
  logic [27:0] w_trial;
  logic [23:0] w_root;

  always_comb begin
    w_n     = (i_dot > 0) ? {i_dot, 16'h0000} : 48'h0;
    w_rem   = '0;
    w_trial = '0;
    w_root  = '0;
    // Two radicand bits per step, MSB pair first; remainder stays below 2^27.
    for (int i = 23; i >= 0; i--) begin
      w_rem   = {w_rem[25:0], w_n[2*i+1 -: 2]};
      w_trial = {2'b00, w_root, 2'b01};
      if (w_rem >= w_trial) begin
        w_rem  = w_rem - w_trial;
        w_root = {w_root[22:0], 1'b1};
      end else begin
        w_root = {w_root[22:0], 1'b0};
      end
    end
  end

  assign o_len = {8'h00, w_root};
endmodule

// File: rtl/q16_normalize_seq.sv
// Single-in-flight Q16.16 vector normalizer: len = |v|, out = v/len, zero flag when len <= ZERO_THRESH.
// Latency: out_valid 5 edges after accept (2 on the zero path); one vector per >= 7 cycles.
// Backpressure: in_ready only in IDLE; results held in OUT until out_valid && out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_x/in_y/in_z;
//        out_valid/out_ready/out_x/out_y/out_z/out_len/out_zero; busy.
module q16_normalize_seq
  import q16_pkg::*;
#(
  parameter q16_t ZERO_THRESH = 32'sd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic [31:0] out_len,
  output logic        out_zero,
  output logic        busy
);
  state_t r_state, w_next;

  q16_t r_x, r_y, r_z;
  q16_t r_dot;
  q16_t r_len;
  q16_t r_out_x, r_out_y, r_out_z;
  logic r_zero;

  q16_t w_dot, w_len, w_quo;
  q16_t w_div_num, w_div_den;
  logic w_is_zero;

  q16_dot3 u_dot3 (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_z   (r_z),
    .o_dot (w_dot)
  );

  q16_sqrt u_sqrt (
    .i_dot (r_dot),
    .o_len (w_len)
  );

  // Single shared divider; the divisor falls back to 1.0 outside the divide
  // states so it never sees zero, even while r_len is still 0 after reset.
  always_comb begin
    w_div_num = '0;
    w_div_den = Q16_ONE;
    case (r_state)
      S_DIVX: begin w_div_num = r_x; w_div_den = r_len; end
      S_DIVY: begin w_div_num = r_y; w_div_den = r_len; end
      S_DIVZ: begin w_div_num = r_z; w_div_den = r_len; end
      default: ;
    endcase
  end

  q16_div u_div (
    .i_num (w_div_num),
    .i_den (w_div_den),
    .o_quo (w_quo)
  );

  assign w_is_zero = (w_len <= ZERO_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_DOT;
      S_DOT:   w_next = S_SQRT;
      S_SQRT:  w_next = w_is_zero ? S_OUT : S_DIVX;
      S_DIVX:  w_next = S_DIVY;
      S_DIVY:  w_next = S_DIVZ;
      S_DIVZ:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_dot   <= '0;
      r_len   <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_out_z <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x <= in_x;
            r_y <= in_y;
            r_z <= in_z;
          end
        end
        S_DOT:  r_dot <= w_dot;
        S_SQRT: begin
          r_len  <= w_len;
          r_zero <= w_is_zero;
          if (w_is_zero) begin
            r_out_x <= '0;
            r_out_y <= '0;
            r_out_z <= '0;
          end
        end
        S_DIVX: r_out_x <= w_quo;
        S_DIVY: r_out_y <= w_quo;
        S_DIVZ: r_out_z <= w_quo;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;
  assign out_len   = r_len;
  assign out_zero  = r_zero;
endmodule

// File: tb/tb_q16_normalize_seq.sv
// Scoreboard bench for q16_normalize_seq: driver pushes reference results, negedge monitor pops/compares.
// Latency: checks 5-edge (normal) / 2-edge (zero) accept-to-valid timing.
// Backpressure: out_ready held high, randomized, or held low for stall cases.
module tb_q16_normalize_seq;
  localparam logic signed [31:0] TB_THRESH = 32'sd0;

  typedef struct {
    int x;
    int y;
    int z;
    int len;
    bit zero;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_x, out_y, out_z, out_len;
  logic        out_zero;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = -1;
  int   rdy_mode = 0;
  bit   seen = 1'b0;
  exp_t sb[$];

  q16_normalize_seq #(.ZERO_THRESH(TB_THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_len   (out_len),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the Q16.16 definitions.
  function automatic exp_t model(input int x, input int y, input int z, input int acc);
    exp_t   e;
    longint n, lo, hi, mid;
    int     dot;
    dot = int'(((longint'(x) * longint'(x)) >>> 16) +
               ((longint'(y) * longint'(y)) >>> 16) +
               ((longint'(z) * longint'(z)) >>> 16));
    lo = 0;
    if (dot > 0) begin
      n  = longint'(dot) <<< 16;
      hi = 64'd1 << 24;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mid * mid <= n) lo = mid;
        else                hi = mid;
      end
    end
    e.len  = int'(lo);
    e.zero = (e.len <= TB_THRESH);
    e.acc  = acc;
    if (e.zero) begin
      e.x = 0; e.y = 0; e.z = 0;
    end else begin
      e.x = int'((longint'(x) <<< 16) / lo);
      e.y = int'((longint'(y) <<< 16) / lo);
      e.z = int'((longint'(z) <<< 16) / lo);
    end
    return e;
  endfunction

  // Called at posedge+#1; returns at accept edge+#1 with in_valid dropped.
  task automatic send(input int x, input int y, input int z, input bit push, output int acc);
    int n;
    in_valid = 1'b1;
    in_x = x; in_y = y; in_z = z;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready 0 required=in_ready 1");
    end
    acc = cyc + 1;
    if (push) sb.push_back(model(x, y, z, acc));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out actual=out_valid 1 required=out_valid 0 (t=%0t)", $time);
      end else begin
        e = sb[0];
        if (!seen) begin
          chk("latency", cyc, e.acc + (e.zero ? 2 : 5));
          seen = 1'b1;
        end
        chk("out_x",    out_x,    e.x);
        chk("out_y",    out_y,    e.y);
        chk("out_z",    out_z,    e.z);
        chk("out_len",  out_len,  e.len);
        chk("out_zero", out_zero, e.zero);
        chk("busy_out", busy,     1);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
          last_hs = cyc + 1;
        end
      end
    end
  end

  function automatic int rand_comp(input int kind);
    case (kind)
      0:       return $signed($urandom_range(0, 32'h0100_0000)) - 32'sh0080_0000;
      1:       return $signed($urandom);
      2:       return $signed($urandom_range(0, 6)) - 3;
      default: return ($urandom_range(0, 1) == 1) ? 0 : ($signed($urandom_range(0, 64)) - 32) <<< 16;
    endcase
  endfunction

  initial begin
    int acc, acc2, n, k;

    // Reset state
    #3;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_len",   out_len,   0);
    chk("rst_out_zero",  out_zero,  0);
    chk("rst_out_x",     out_x,     0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // (3,4,0) then (-3,4,0) back to back
    send(32'sh0003_0000, 32'sh0004_0000, 0, 1'b1, acc);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_busy",     in_ready, 0);
    send(-32'sh0003_0000, 32'sh0004_0000, 0, 1'b1, acc2);
    chk("b2b_accept", acc2, last_hs + 1);

    // Zero vectors, direct and via wrap
    send(0, 0, 0, 1'b1, acc);
    send(32'sh0100_0000, 0, 0, 1'b1, acc);
    repeat (8) @(posedge clk);
    #1;
    chk("idle_hold_len",  out_len,  0);
    chk("idle_hold_zero", out_zero, 1);

    // Stall in OUT with in_valid/data toggling
    rdy_mode = 2; out_ready = 1'b0;
    send(-32'sh0003_0000, 32'sh0004_0000, 0, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1)) | (i == 0);
      in_x = $urandom; in_y = $urandom; in_z = $urandom;
      chk("stall_in_ready",  in_ready,  0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_mode = 0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  in_ready,  1);
    chk("release_out_valid", out_valid, 0);

    // Reset while in DIVY; this vector must never appear
    send(32'sh0003_0000, 32'sh0004_0000, 0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_x",     out_x,     0);
    chk("mid_rst_out_y",     out_y,     0);
    chk("mid_rst_out_z",     out_z,     0);
    chk("mid_rst_out_len",   out_len,   0);
    chk("mid_rst_out_zero",  out_zero,  0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready",  in_ready,  1);
    chk("mid_rst_busy",      busy,      0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    send(32'sh0003_0000, 32'sh0004_0000, 0, 1'b1, acc);

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int v = 0; v < 40; v++) begin
      k = $urandom_range(0, 3);
      send(rand_comp(k), rand_comp(k), rand_comp(k), 1'b1, acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    rdy_mode = 0;
    chk("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
